// File: rtl/dataflow_deadlock_monitor.sv
// rtl/dataflow_deadlock_monitor.sv - wait-for graph deadlock detector for dataflow processes
//
// Watches an NPROC x NPROC wait-for matrix. Once the matrix has been nonzero
// and unchanged for STALL_CYC cycles, a frozen snapshot is searched one origin
// at a time for a cycle through that origin, using forward (reachable-from)
// and backward (reaches-to) set expansion. A found cycle is latched and held
// until acknowledged.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   enable     in   monitor enable (REPORT ignores it)
//   blk        in   wait-for matrix, blk[i*NPROC+j] = process i waits on j
//   dl_ack     in   clears a held report
//   dl_detect  out  cycle found and held
//   dl_origin  out  one-hot origin of the reported cycle
//   dl_members out  processes on the reported cycle
//   dl_count   out  saturating count of reports since reset
//   busy       out  high while watching or searching
module dataflow_deadlock_monitor #(
  parameter int NPROC     = 3,
  parameter int STALL_CYC = 16,
  parameter int CNT_W     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NPROC*NPROC-1:0] blk,
  input  logic                   dl_ack,
  output logic                   dl_detect,
  output logic [NPROC-1:0]       dl_origin,
  output logic [NPROC-1:0]       dl_members,
  output logic [CNT_W-1:0]       dl_count,
  output logic                   busy
);

  localparam int N2 = NPROC * NPROC;
  localparam int OW = (NPROC > 1) ? $clog2(NPROC) : 1;
  localparam int SW = $clog2(NPROC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WATCH,
    S_SEARCH,
    S_NOCYC,
    S_REPORT
  } state_t;

  state_t           r_state;
  logic [N2-1:0]    r_snap;
  logic [15:0]      r_stall_cnt;
  logic [NPROC-1:0] r_f;
  logic [NPROC-1:0] r_b;
  logic [SW-1:0]    r_step;
  logic [OW-1:0]    r_origin;
  logic             r_load;
  logic             r_detect;
  logic [NPROC-1:0] r_origin_oh;
  logic [NPROC-1:0] r_members;
  logic [CNT_W-1:0] r_count;

  logic [NPROC-1:0] w_row [NPROC];
  logic [NPROC-1:0] w_col [NPROC];
  logic [NPROC-1:0] w_f_next;
  logic [NPROC-1:0] w_b_next;
  logic [OW-1:0]    w_first_idx;
  logic [OW-1:0]    w_next_idx;
  logic             w_next_vld;
  logic [NPROC-1:0] w_origin_oh;

  // Rows (who i waits on) and columns (who waits on j) of the frozen snapshot.
  always_comb begin
    for (int i = 0; i < NPROC; i++) begin
      w_row[i] = '0;
      w_col[i] = '0;
    end
    for (int i = 0; i < NPROC; i++) begin
      for (int j = 0; j < NPROC; j++) begin
        w_row[i][j] = r_snap[i*NPROC+j];
        w_col[j][i] = r_snap[i*NPROC+j];
      end
    end
  end

  // One expansion step of the forward and backward sets, plus origin selection.
  always_comb begin
    w_f_next    = r_f;
    w_b_next    = r_b;
    w_first_idx = '0;
    w_next_idx  = '0;
    w_next_vld  = 1'b0;
    for (int i = 0; i < NPROC; i++) begin
      if (r_f[i]) w_f_next = w_f_next | w_row[i];
      if (r_b[i]) w_b_next = w_b_next | w_col[i];
    end
    // Scanning downward leaves the lowest qualifying index in place.
    for (int i = NPROC - 1; i >= 0; i--) begin
      if (|w_row[i]) begin
        w_first_idx = OW'(i);
        if (OW'(i) > r_origin) begin
          w_next_idx = OW'(i);
          w_next_vld = 1'b1;
        end
      end
    end
  end

  assign w_origin_oh = NPROC'(1) << r_origin;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_snap      <= '0;
      r_stall_cnt <= '0;
      r_f         <= '0;
      r_b         <= '0;
      r_step      <= '0;
      r_origin    <= '0;
      r_load      <= 1'b0;
      r_detect    <= 1'b0;
      r_origin_oh <= '0;
      r_members   <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable && (|blk)) begin
            r_state     <= S_WATCH;
            r_snap      <= blk;
            r_stall_cnt <= 16'd1;
          end
        end

        S_WATCH: begin
          if (!enable || !(|blk)) begin
            r_state <= S_IDLE;
          end else if (blk != r_snap) begin
            r_snap      <= blk;
            r_stall_cnt <= 16'd1;
          end else if (r_stall_cnt == 16'(STALL_CYC)) begin
            r_state  <= S_SEARCH;
            r_origin <= w_first_idx;
            r_load   <= 1'b1;
          end else begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
          end
        end

        S_SEARCH: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_load  <= 1'b0;
          end else if (r_load) begin
            r_f    <= w_row[r_origin];
            r_b    <= w_col[r_origin];
            r_step <= SW'(1);
            r_load <= 1'b0;
          end else if (r_step == SW'(NPROC)) begin
            if (r_f[r_origin]) begin
              r_state     <= S_REPORT;
              r_detect    <= 1'b1;
              r_origin_oh <= w_origin_oh;
              r_members   <= (r_f & r_b) | w_origin_oh;
              if (r_count != '1) r_count <= r_count + CNT_W'(1);
            end else if (w_next_vld) begin
              // Next origin's first load overlaps the verdict on this one.
              r_origin <= w_next_idx;
              r_f      <= w_row[w_next_idx];
              r_b      <= w_col[w_next_idx];
              r_step   <= SW'(1);
            end else begin
              r_state <= S_NOCYC;
            end
          end else begin
            r_f    <= w_f_next;
            r_b    <= w_b_next;
            r_step <= r_step + SW'(1);
          end
        end

        S_NOCYC: begin
          // An unchanged matrix was already proven acyclic; wait for it to move.
          if (!enable || (blk != r_snap)) r_state <= S_IDLE;
        end

        S_REPORT: begin
          if (dl_ack) begin
            r_state     <= S_IDLE;
            r_detect    <= 1'b0;
            r_origin_oh <= '0;
            r_members   <= '0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dl_detect  = r_detect;
  assign dl_origin  = r_origin_oh;
  assign dl_members = r_members;
  assign dl_count   = r_count;
  assign busy       = (r_state == S_WATCH) || (r_state == S_SEARCH);

endmodule
